// File: rtl/outer_in_widen32_pkg.sv
// outer_in_widen32_pkg: shared widths, packer states and the saturating word-count helper
package outer_in_widen32_pkg;
  localparam int Outer_MaxWordLen = 15;
  typedef logic [Outer_MaxWordLen-1:0] wcnt_t;
  typedef enum logic {EMPTY, HAVE_LO} state_e;
  function automatic wcnt_t sat_inc(input wcnt_t v);
    return (&v) ? v : v + wcnt_t'(1);
  endfunction
endpackage

// File: rtl/bus_slot64.sv
// bus_slot64: single-entry output register for a 64-bit word with last flag and word count
module bus_slot64
  import outer_in_widen32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic [63:0] data_i,
  input  logic        last_i,
  input  wcnt_t       cnt_i,
  input  logic        canReceive_i,
  output logic        isReady_o,
  output logic        free_o,
  output logic [63:0] data_o,
  output logic        last_o,
  output wcnt_t       cnt_o
);
  logic        valid_q, valid_d;
  logic [63:0] data_q;
  logic        last_q;
  wcnt_t       cnt_q;
  assign valid_d   = load_i | (valid_q & ~canReceive_i);
  assign free_o    = ~valid_q | canReceive_i;
  assign isReady_o = valid_q;
  assign data_o    = data_q;
  assign last_o    = last_q;
  assign cnt_o     = cnt_q;
  // payload only changes on load, so it stays put while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (load_i) begin
        data_q <= data_i;
        last_q <= last_i;
        cnt_q  <= cnt_i;
      end
    end
  end
endmodule

// File: rtl/outer_in_widen32.sv
// outer_in_widen32: packs pairs of 32-bit halves into 64-bit words, padding odd-length messages
module outer_in_widen32
  import outer_in_widen32_pkg::*;
#(
  parameter bit          FIRST_LOW = 1'b1,
  parameter logic [31:0] PAD       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_isReady,
  output logic        in_canReceive,
  input  logic        in_isLast,
  output logic [63:0] out,
  output logic        out_isReady,
  input  logic        out_canReceive,
  output logic        out_isLast,
  output wcnt_t       out_msgWords
);
  state_e      state_q, state_d;
  logic [31:0] held_q, held_d;
  wcnt_t       wcnt_q, wcnt_d;
  logic        xfer, first, load;
  logic [31:0] lo, hi;
  wcnt_t       cnt_nx;
  assign xfer   = in_isReady & in_canReceive;
  assign first  = state_q == EMPTY;
  assign lo     = first ? in : held_q;
  assign hi     = first ? PAD : in;
  assign load   = xfer & (~first | in_isLast);
  assign cnt_nx = sat_inc(wcnt_q);
  // a lone first half waits in held_q; a last half or a second half completes a word
  always_comb begin
    state_d = xfer ? ((first & ~in_isLast) ? HAVE_LO : EMPTY) : state_q;
    held_d  = (xfer & first & ~in_isLast) ? in : held_q;
    wcnt_d  = load ? (in_isLast ? '0 : cnt_nx) : wcnt_q;
  end
  // packer state, held half and per-message word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      held_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      wcnt_q  <= wcnt_d;
    end
  end
  bus_slot64 u_slot (
    .clk          (clk),
    .rst_n        (rst),
    .load_i       (load),
    .data_i       (FIRST_LOW ? {hi, lo} : {lo, hi}),
    .last_i       (in_isLast),
    .cnt_i        (cnt_nx),
    .canReceive_i (out_canReceive),
    .isReady_o    (out_isReady),
    .free_o       (in_canReceive),
    .data_o       (out),
    .last_o       (out_isLast),
    .cnt_o        (out_msgWords)
  );
endmodule
